// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between an issuing RV32 core and muldiv_unit.
// The master drives the request side, the slave (muldiv_unit) drives the completion side.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     start;
    logic [2:0]               op;
    logic [DATA_WIDTH-1:0]    src_a;
    logic [DATA_WIDTH-1:0]    src_b;
    logic [ADDRESS_WIDTH-1:0] rd_in;
    logic                     busy;
    logic                     done;
    logic [DATA_WIDTH-1:0]    result;
    logic [ADDRESS_WIDTH-1:0] rd_out;
    logic                     we;

    modport master (output start, op, src_a, src_b, rd_in,
                    input  busy, done, result, rd_out, we);
    modport slave  (input  start, op, src_a, src_b, rd_in,
                    output busy, done, result, rd_out, we);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a fixed 33-cycle start-to-done latency.
// Define MULDIV_MUL_EN to build the shift-add multiplier; without it only divide ops produce results.
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int         W         = DATA_WIDTH;
    localparam logic [5:0] LAST_ITER = 6'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e                   state_q, state_d;
    logic [5:0]               cnt_q, cnt_d;
    logic [2*W-1:0]           acc_q, acc_d;
    logic [W-1:0]             opb_q, opb_d;
    logic                     is_div_q, is_div_d;
    logic                     is_rem_q, is_rem_d;
    logic                     neg_res_q, neg_res_d;
    logic                     neg_rem_q, neg_rem_d;
    logic                     div_zero_q, div_zero_d;
    logic [ADDRESS_WIDTH-1:0] rd_lat_q, rd_lat_d;
    logic [ADDRESS_WIDTH-1:0] rd_out_q, rd_out_d;
    logic [W-1:0]             result_q, result_d;

    logic           accept, signed_a, signed_b, a_neg, b_neg, writes_ok;
    logic [W-1:0]   a_mag, b_mag, quo, rem, fin;
    logic [W:0]     div_up, div_diff;
    logic [2*W-1:0] acc_nx;

    assign accept = (state_q == IDLE) && bus.start;

    // Signedness is resolved once at acceptance; the iterations only ever see magnitudes.
    always_comb begin
        signed_a = bus.op[2] ? !bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
        signed_b = bus.op[2] ? !bus.op[0] : (bus.op[1:0] == 2'b01);
        a_neg    = signed_a && bus.src_a[W-1];
        b_neg    = signed_b && bus.src_b[W-1];
        a_mag    = a_neg ? -bus.src_a : bus.src_a;
        b_mag    = b_neg ? -bus.src_b : bus.src_b;
    end

`ifdef MULDIV_MUL_EN
    logic           mul_hi_q, mul_hi_d;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] prod;

    assign mul_hi_d  = (bus.op[1:0] != 2'b00);
    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    assign writes_ok = 1'b1;

    always_ff @(posedge clk) begin
        if (accept) mul_hi_q <= mul_hi_d;
    end
`else
    assign writes_ok = is_div_q;
`endif

    // One iteration step plus the sign fix-up applied to its outcome.
    always_comb begin
        div_up   = acc_q[2*W-1:W-1];
        div_diff = div_up - {1'b0, opb_q};
        acc_nx   = acc_q;
        if (is_div_q) begin
            acc_nx = div_diff[W] ? {acc_q[2*W-2:0], 1'b0}
                                 : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end
`ifdef MULDIV_MUL_EN
        else begin
            acc_nx = {mul_sum, acc_q[W-1:1]};
        end
        prod = neg_res_q ? -acc_nx : acc_nx;
`endif
        quo = acc_nx[W-1:0];
        rem = acc_nx[2*W-1:W];
        fin = '0;
        if (is_div_q) begin
            if (is_rem_q)        fin = neg_rem_q ? -rem : rem;
            else if (div_zero_q) fin = '1;
            else                 fin = neg_res_q ? -quo : quo;
        end
`ifdef MULDIV_MUL_EN
        else begin
            fin = mul_hi_q ? prod[2*W-1:W] : prod[W-1:0];
        end
`endif
    end

    // NOTE: every next-state signal takes its current value first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        is_rem_d   = is_rem_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        rd_lat_d   = rd_lat_q;
        rd_out_d   = rd_out_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d      = {{W{1'b0}}, a_mag};
                    opb_d      = b_mag;
                    is_div_d   = bus.op[2];
                    is_rem_d   = bus.op[1];
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = (bus.src_b == '0);
                    rd_lat_d   = bus.rd_in;
                    cnt_d      = '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    result_d = fin;
                    rd_out_d = rd_lat_q;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register updating from the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
        end
    end

    // NOTE: operand/datapath registers carry no reset; they are always loaded on acceptance before use.
    always_ff @(posedge clk) begin
        acc_q      <= acc_d;
        opb_q      <= opb_d;
        is_div_q   <= is_div_d;
        is_rem_q   <= is_rem_d;
        neg_res_q  <= neg_res_d;
        neg_rem_q  <= neg_rem_d;
        div_zero_q <= div_zero_d;
        rd_lat_q   <= rd_lat_d;
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
    assign bus.we     = bus.done && (rd_out_q != '0) && writes_ok;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand and result width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, the destination register index width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1: rising-edge clock.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port start  input  1: request a new operation; sampled only in IDLE.
REQ-007 Port op  input  3: RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port src_a  input  DATA_WIDTH: rs1 operand, taken from register-file RD1.
REQ-009 Port src_b  input  DATA_WIDTH: rs2 operand, taken from register-file RD2.
REQ-010 Port rd_in  input  ADDRESS_WIDTH: destination register index.
REQ-011 Port busy  output  1: high while an operation is in flight (CALC or DONE).
REQ-012 Port done  output  1: one-cycle completion pulse.
REQ-013 Port result  output  DATA_WIDTH: final value, drives register-file WD3.
REQ-014 Port rd_out  output  ADDRESS_WIDTH: latched rd_in, drives register-file A3.
REQ-015 Port we  output  1: write enable, drives register-file WE3.

Function
REQ-016 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-017 IDLE with start=1 SHALL latch op, src_a, src_b and rd_in, then enter CALC; inputs are ignored after the latch.
REQ-018 start SHALL be ignored while busy=1; it is neither queued nor an error.
REQ-019 CALC SHALL run exactly 32 iterations, one per cycle, using a 6-bit counter.
REQ-020 Multiply SHALL be radix-2 shift-add over a 64-bit product.
REQ-021 Divide SHALL be restoring division on magnitudes, with signs fixed up after the final iteration.
REQ-022 Operand signedness: MULH signed x signed; MULHSU signed x unsigned; MULHU, DIVU and REMU unsigned.
REQ-023 Result selection: MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32].
REQ-024 Latency SHALL be fixed: with start sampled in cycle 0, done=1 in cycle 33 for every op, including the special cases.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE; a new start is accepted in cycle 34.
REQ-026 result and rd_out SHALL hold their values after done until the next completion.
REQ-027 we SHALL equal done, except we=0 when rd_out=0 (x0 is never written).
REQ-028 Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return src_a.
REQ-029 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
REQ-030 The signed remainder SHALL take the sign of the dividend.
REQ-031 busy SHALL be 0 in IDLE and 1 in CALC and DONE.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE, zero the counter, and set busy=0, done=0, we=0, result=0 and rd_out=0.
REQ-033 Reset mid-operation SHALL abort the operation with no done pulse and no write.
REQ-034 A start in the first cycle after rst deasserts SHALL be accepted normally.

Configuration
REQ-035 The macro MULDIV_MUL_EN defined SHALL enable MUL, MULH, MULHSU and MULHU as specified above.
REQ-036 With MULDIV_MUL_EN undefined, the multiply datapath SHALL be absent.
- op[2]=0 is still accepted and keeps the 33-cycle latency.
- done pulses with result=0 and we=0.
- Divide behaviour is unchanged.

Verification
REQ-037 MUL: src_a=7, src_b=-3 (0xFFFFFFFD), rd_in=5 -> cycle 33 gives done=1, we=1, rd_out=5, result=0xFFFFFFEB.
REQ-038 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MULH with the same operands -> result=0x00000000.
REQ-039 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000 / -1 -> 0x80000000.
REQ-040 start pulsed again in cycles 1-33 with different operands -> ignored, first result unchanged; start in cycle 34 is accepted.
REQ-041 rst asserted in cycle 10 of an operation -> no done or we pulse, busy=0 and result=0 in the next cycle.
REQ-042 rd_in=0 with DIVU 9/3 -> done=1, result=3, we=0.
